// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: occupancy and elastic-stage state encodings.
package lc3b_types;

  typedef logic [1:0] pipe_occ_t;

  // Encoded as {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'b00,
    PS_ONE   = 2'b10,
    PS_FULL  = 2'b11
  } pipe_stage_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload register plus valid bit, with load, synchronous reset and flush clear.
module pipe_slot #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      if (CLEAR_DATA) r_data <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_load) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: main slot plus skid slot, with a fully registered in_ready.
module pipe_stage_elastic
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output pipe_occ_t        occupancy
);

  logic              w_main_v, w_skid_v;
  logic [WIDTH-1:0]  w_skid_data;
  logic              w_main_load, w_main_vd, w_skid_load, w_skid_vd;
  logic [WIDTH-1:0]  w_main_din;
  logic              w_in_fire, w_out_fire;
  logic              r_in_ready;
  pipe_stage_state_t w_state;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = w_main_v & out_ready;
  assign w_state    = pipe_stage_state_t'({w_main_v, w_skid_v});

  always_comb begin
    w_main_load = 1'b0;
    w_main_vd   = w_main_v;
    w_main_din  = in_data;
    w_skid_load = 1'b0;
    w_skid_vd   = w_skid_v;
    unique case (w_state)
      PS_EMPTY: begin
        if (w_in_fire) begin
          w_main_load = 1'b1;
          w_main_vd   = 1'b1;
        end
      end
      PS_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_skid_load = 1'b1;
          w_skid_vd   = 1'b1;
        end else if (w_out_fire) begin
          w_main_vd = 1'b0;
        end
      end
      PS_FULL: begin
        // in_ready is low here, so only the drain path exists.
        if (w_out_fire) begin
          w_main_load = 1'b1;
          w_main_din  = w_skid_data;
          w_skid_vd   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  pipe_slot #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_load  (w_main_load),
    .i_valid (w_main_vd),
    .i_data  (w_main_din),
    .o_valid (w_main_v),
    .o_data  (out_data)
  );

  pipe_slot #(
    .WIDTH      (WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_load  (w_skid_load),
    .i_valid (w_skid_vd),
    .i_data  (in_data),
    .o_valid (w_skid_v),
    .o_data  (w_skid_data)
  );

  // Registered from next-state skid valid so back-pressure never chains combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) r_in_ready <= 1'b1;
    else                 r_in_ready <= !w_skid_vd;
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(w_skid_v && !w_main_v));
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_v;
  assign occupancy = pipe_occ_t'({1'b0, w_main_v}) + pipe_occ_t'({1'b0, w_skid_v});

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed EX/MEM stage register. Generic elastic pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Synchronous flush. Upstream `in_ready` is fully registered, so stall back-pressure no longer forms a combinational chain through the pipeline.
- Instanced between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The packed control word and data bundle are carried as one `WIDTH`-bit vector.

Parameters:
- `WIDTH`, 16: payload bits per entry; legal range 1..512.
- `CLEAR_DATA`, 1: 1 = flush and reset also zero stored payload; 0 = only valid bits cleared.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream has a payload.
- `in_data`  in  WIDTH  upstream payload.
- `in_ready`  out  1  stage can accept; a registered output.
- `out_valid`  out  1  payload presented downstream.
- `out_data`  out  WIDTH  downstream payload.
- `out_ready`  in  1  downstream accepts.
- `flush`  in  1  squash all held entries (branch mispredict / trap).
- `occupancy`  out  2  number of held entries, 0..2.

Behaviour:
- Reset: on a clk edge with `rst_n`=0, the stage enters state EMPTY.
  - `out_valid`=0, `occupancy`=0, `in_ready`=1 from the first cycle after reset.
  - `out_data`=0 and skid payload=0 (both `CLEAR_DATA` settings).
  - Reset asserted mid-transfer drops all entries; the handshake that cycle is ignored.
- Storage: main register (`out_data`/`out_valid`) and skid register (`skid_data`/`skid_valid`).
  - `in_ready` = !`skid_valid`, registered.
  - `occupancy` = `out_valid` + `skid_valid`.
- Fire events: `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- State machine on {`out_valid`, `skid_valid`}: EMPTY(0,0), ONE(1,0), FULL(1,1). State (0,1) is illegal, and an assertion must check it.
- EMPTY:
  - `in_fire` -> main <= `in_data`; go to ONE.
  - Otherwise hold.
- ONE:
  - `in_fire` & `out_fire` -> main <= `in_data`; stay in ONE.
  - `in_fire` & !`out_fire` -> skid <= `in_data`; go to FULL.
  - !`in_fire` & `out_fire` -> go to EMPTY.
  - Otherwise hold.
- FULL:
  - `in_ready`=0, so there is no `in_fire`.
  - `out_fire` -> main <= skid; skid invalid; go to ONE.
  - Otherwise hold; both payloads stable.
- Latency and throughput: 1 cycle `in_data` -> `out_data` when not stalled. Sustained throughput is 1 per cycle with `out_ready` held high.
- Ordering: strict FIFO; no payload duplicated or lost except by flush.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_data` must not change.
- Flush: the next state is EMPTY regardless of other inputs.
  - An `in_fire` in the flush cycle is dropped.
  - An `out_fire` in the flush cycle still completes downstream (this cycle's `out_data` is consumed).
  - `CLEAR_DATA`=1 zeroes both payloads; `CLEAR_DATA`=0 leaves them unchanged.
  - `in_ready`=1 in the cycle after flush.
- Precedence of simultaneous events: `rst_n` low > `flush` > handshake.
- No X propagation: `in_data` is ignored when `in_valid`=0.

Decomposition:
- Add to the shared `lc3b_types` package:
  - `pipe_occ_t` (2-bit occupancy typedef).
  - Enum `pipe_stage_state_t` {`PS_EMPTY`, `PS_ONE`, `PS_FULL`}, used for debug/assertion visibility.
- Callers size `WIDTH` with `$bits()` of their packed control/data struct, e.g. `lc3b_control_word_mem` concatenated with operand words.
- One sub-module is natural: `pipe_slot`.
  - Contents: a `WIDTH`-wide payload register plus valid bit, with load, sync active-low reset, and clear.
  - Instanced twice, as main and skid.
  - Control logic stays in `pipe_stage_elastic`.

Test Plan:
1. Reset, then stream with no stall.
   - Stimulus: `rst_n`=0 for 2 cycles, then stream 0x0001..0x0008 with `in_valid`=1, `out_ready`=1.
   - Required: `out_data` 0x0001..0x0008 in consecutive cycles, 1 cycle behind input; `in_ready` stays 1; `occupancy` ≤ 1.
2. Downstream stall fills the skid.
   - Stimulus: send 0x00A1, 0x00A2, 0x00A3 with `out_ready`=0.
   - Required: A1 held on `out_data`; A2 in skid; `occupancy`=2; `in_ready`=0 next cycle; A3 held upstream.
   - Then set `out_ready`=1. Required: A1, A2, A3 in order, no gaps after A1.
3. Flush while FULL.
   - Stimulus: in state FULL, assert `flush` with `in_valid`=1 and `in_data`=0x00FF.
   - Required: next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1; 0x00FF never appears; `out_data`=0 when `CLEAR_DATA`=1.
4. Flush and `out_fire` in the same cycle.
   - Stimulus: in ONE holding 0x1234, `out_ready`=1 and `flush`=1.
   - Required: 0x1234 is counted as delivered this cycle; EMPTY next cycle.
5. Reset mid-operation.
   - Stimulus: in FULL (0x5555 main, 0x6666 skid), `rst_n`=0 for 1 cycle.
   - Required: `out_valid`=0, `out_data`=0, `occupancy`=0; `in_ready`=1 after release.
6. Random back-pressure with `WIDTH`=75.
   - Stimulus: 1000 payloads, `in_valid` and `out_ready` each randomised at 50%.
   - Required: scoreboard shows in-order, lossless delivery; `out_data` stable during stalls; state (0,1) never reached.
